// File: rtl/kb_div_pkg.sv
// kb_div_pkg: shared FSM state type and sign-handling helpers for the sequential divider
//   MAXW     widest operand the helpers accept (operands are zero-extended into it)
//   neg_fix  two's-complement negate when neg is set, otherwise pass through
//   abs_val  magnitude of a w-bit value, signed when sgn is set; min value maps to 2^(w-1)
package kb_div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
   localparam int MAXW = 64;
   function automatic logic [MAXW-1:0] neg_fix(input logic [MAXW-1:0] v, input logic neg);
      return neg ? ~v + MAXW'(1) : v;
   endfunction
   function automatic logic [MAXW-1:0] abs_val(input logic [MAXW-1:0] v, input int w, input logic sgn);
      logic neg;
      logic [MAXW-1:0] ext;
      neg = sgn & v[6'(w - 1)];
      // sign-extend before negating so the magnitude is exact in any wider slice
      ext = neg ? v | ({MAXW{1'b1}} << w) : v;
      return neg_fix(ext, neg);
   endfunction
endpackage

// File: rtl/kb_div_step.sv
// kb_div_step: one combinational restoring-division step
//   prem      in   DW+1  partial remainder (always below dvs)
//   din       in   1     next dividend bit, MSB first
//   dvs       in   DW+1  divisor magnitude
//   prem_nxt  out  DW+1  partial remainder after this step
//   qbit      out  1     quotient bit produced by this step
module kb_div_step #(
   parameter int DW = 4
) (
   input  logic [DW:0] prem,
   input  logic        din,
   input  logic [DW:0] dvs,
   output logic [DW:0] prem_nxt,
   output logic        qbit
);
   logic [DW+1:0] t, d;
   always_comb begin
      t = {prem, din};
      d = t - {1'b0, dvs};
      qbit = ~d[DW+1];
      prem_nxt = qbit ? d[DW:0] : t[DW:0];
   end
endmodule

// File: rtl/kb_divn_seq.sv
// kb_divn_seq: sequential SIZE/DW-bit integer divider, unsigned or signed (truncating), valid/ready on both sides
//   sys_clock    in   1     system clock, rising edge
//   reset_n      in   1     asynchronous active-low reset
//   in_valid     in   1     operands valid
//   in_ready     out  1     divider can accept operands
//   dividend     in   SIZE  dividend
//   divisor      in   DW    divisor
//   signed_mode  in   1     1 = signed, 0 = unsigned; sampled with operands
//   out_valid    out  1     result valid
//   out_ready    in   1     downstream accepts result
//   quotient     out  SIZE  quotient
//   remainder    out  DW    remainder
//   div_by_zero  out  1     divisor was zero for this result
module kb_divn_seq
   import kb_div_pkg::*;
#(
   parameter int SIZE = 20,
   parameter int DW   = 4
) (
   input  logic            sys_clock,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] dividend,
   input  logic [DW-1:0]   divisor,
   input  logic            signed_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] quotient,
   output logic [DW-1:0]   remainder,
   output logic            div_by_zero
);
   localparam int CW = $clog2(SIZE);
   div_state_t state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [SIZE-1:0] dvd_sr, q_fin;
   logic [DW:0]     dvs_mag, prem, prem_nxt;
   logic            dvd_neg, dvs_neg, qbit, accept;
   // dvd_sr shifts dividend bits out of the top while quotient bits enter at the bottom
   kb_div_step #(.DW(DW)) u_step (
      .prem     (prem),
      .din      (dvd_sr[SIZE-1]),
      .dvs      (dvs_mag),
      .prem_nxt (prem_nxt),
      .qbit     (qbit)
   );
   always_comb begin
      in_ready = state == IDLE;
      out_valid = state == DONE;
      accept = in_valid && state == IDLE;
      q_fin = {dvd_sr[SIZE-2:0], qbit};
      state_nxt = state;
      if (accept) state_nxt = divisor == '0 ? DONE : CALC;
      if (state == CALC && cnt == '0) state_nxt = DONE;
      if (state == DONE && out_ready) state_nxt = IDLE;
   end
   always_ff @(posedge sys_clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         dvd_sr <= '0;
         dvs_mag <= '0;
         prem <= '0;
         dvd_neg <= 1'b0;
         dvs_neg <= 1'b0;
         quotient <= '0;
         remainder <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         dvd_sr <= SIZE'(abs_val(MAXW'(dividend), SIZE, signed_mode));
         dvs_mag <= (DW+1)'(abs_val(MAXW'(divisor), DW, signed_mode));
         dvd_neg <= signed_mode & dividend[SIZE-1];
         dvs_neg <= signed_mode & divisor[DW-1];
         prem <= '0;
         cnt <= CW'(SIZE - 1);
         if (divisor == '0) begin
            quotient <= '1;
            remainder <= dividend[DW-1:0];
            div_by_zero <= 1'b1;
         end
      end else if (state == CALC) begin
         prem <= prem_nxt;
         dvd_sr <= q_fin;
         cnt <= cnt - CW'(1);
         // final step: sign fixup folded into the output register load
         if (cnt == '0) begin
            quotient <= SIZE'(neg_fix(MAXW'(q_fin), dvd_neg ^ dvs_neg));
            remainder <= DW'(neg_fix(MAXW'(prem_nxt), dvd_neg));
            div_by_zero <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_kb_divn_seq.sv
// tb_kb_divn_seq: self-checking bench for kb_divn_seq (SIZE=20, DW=4)
module tb_kb_divn_seq;
   logic        sys_clock, reset_n, in_valid, in_ready, signed_mode, out_valid, out_ready, div_by_zero;
   logic [19:0] dividend, quotient;
   logic [3:0]  divisor, remainder;
   int total = 0;
   int bad = 0;

   kb_divn_seq #(.SIZE(20), .DW(4)) dut (
      .sys_clock   (sys_clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   typedef struct {
      logic [19:0] a;
      logic [3:0]  b;
      logic        sm;
      logic [19:0] q;
      logic [3:0]  r;
      logic        dz;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // reference: plain integer division, SV int '/' and '%' truncate toward zero
   task automatic model(input logic [19:0] a, input logic [3:0] b, input logic sm,
                        output logic [19:0] q, output logic [3:0] r, output logic dz);
      int sa, sb, qi, ri;
      if (b == 0) begin
         q = 20'hFFFFF;
         r = a[3:0];
         dz = 1'b1;
      end else begin
         sa = sm ? int'($signed(a)) : int'(a);
         sb = sm ? int'($signed(b)) : int'(b);
         qi = sa / sb;
         ri = sa % sb;
         q = 20'(qi);
         r = 4'(ri);
         dz = 1'b0;
      end
   endtask

   task automatic run_op(input string nm, input logic [19:0] a, input logic [3:0] b, input logic sm,
                         input logic [19:0] eq, input logic [3:0] er, input logic edz);
      int k;
      @(negedge sys_clock);
      chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
      dividend = a;
      divisor = b;
      signed_mode = sm;
      in_valid = 1'b1;
      @(posedge sys_clock);
      #1 in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 60) begin
         @(posedge sys_clock);
         #1 k++;
      end
      chk({nm, " latency"}, 32'(k), b == 0 ? 32'd1 : 32'd21);
      chk({nm, " quotient"}, 32'(quotient), 32'(eq));
      chk({nm, " remainder"}, 32'(remainder), 32'(er));
      chk({nm, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
      @(posedge sys_clock);
      #1 chk({nm, " valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [19:0] a, q, q0;
      logic [3:0]  b, r, r0;
      logic        sm, dz;
      int k;
      vecs[0]  = '{20'd100,   4'd3,   1'b0, 20'd33,    4'd1,   1'b0};
      vecs[1]  = '{20'hFFFF9, 4'd2,   1'b1, 20'hFFFFD, 4'hF,   1'b0};
      vecs[2]  = '{20'd7,     4'h8,   1'b1, 20'd0,     4'd7,   1'b0};
      vecs[3]  = '{20'h12345, 4'd0,   1'b0, 20'hFFFFF, 4'h5,   1'b1};
      vecs[4]  = '{20'h80000, 4'hF,   1'b1, 20'h80000, 4'h0,   1'b0};
      vecs[5]  = '{20'hFFFFF, 4'd1,   1'b0, 20'hFFFFF, 4'h0,   1'b0};
      vecs[6]  = '{20'hFFFFF, 4'hF,   1'b0, 20'h11111, 4'h0,   1'b0};
      vecs[7]  = '{20'hFFFFF, 4'h8,   1'b1, 20'h0,     4'hF,   1'b0};
      vecs[8]  = '{20'd100,   4'hD,   1'b1, 20'hFFFDF, 4'h1,   1'b0};
      vecs[9]  = '{20'hFFF9C, 4'd3,   1'b1, 20'hFFFDF, 4'hF,   1'b0};
      vecs[10] = '{20'hFFFFF, 4'd0,   1'b1, 20'hFFFFF, 4'hF,   1'b1};
      vecs[11] = '{20'd11,    4'd15,  1'b0, 20'd0,     4'd11,  1'b0};
      reset_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      signed_mode = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (3) @(posedge sys_clock);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst quotient", 32'(quotient), 32'd0);
      chk("rst remainder", 32'(remainder), 32'd0);
      chk("rst div_by_zero", 32'(div_by_zero), 32'd0);
      @(negedge sys_clock) reset_n = 1'b1;
      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].q, vecs[i].r, vecs[i].dz);
      for (int i = 0; i < 40; i++) begin
         a = (i % 8 == 3) ? 20'h80000 : 20'($urandom);
         b = 4'($urandom_range(0, 15));
         sm = 1'($urandom);
         model(a, b, sm, q, r, dz);
         run_op($sformatf("rnd%0d a=%0h b=%0h s=%0d", i, a, b, sm), a, b, sm, q, r, dz);
      end
      // backpressure: result must hold and new operands must be ignored
      out_ready = 1'b0;
      @(negedge sys_clock);
      dividend = 20'd100;
      divisor = 4'd3;
      signed_mode = 1'b0;
      in_valid = 1'b1;
      @(posedge sys_clock);
      #1 in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 60) begin
         @(posedge sys_clock);
         #1 k++;
      end
      chk("bp reached_done", 32'(out_valid), 32'd1);
      q0 = quotient;
      r0 = remainder;
      chk("bp quotient", 32'(q0), 32'd33);
      chk("bp remainder", 32'(r0), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clock);
         in_valid = 1'b1;
         dividend = 20'($urandom);
         divisor = 4'd5;
         chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
         chk($sformatf("bp%0d quotient", i), 32'(quotient), 32'(q0));
         chk($sformatf("bp%0d remainder", i), 32'(remainder), 32'(r0));
      end
      @(negedge sys_clock);
      in_valid = 1'b0;
      chk("bp held out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(posedge sys_clock);
      #1;
      chk("bp xfer out_valid", 32'(out_valid), 32'd0);
      chk("bp xfer in_ready", 32'(in_ready), 32'd1);
      @(posedge sys_clock);
      #1 chk("bp idle in_ready", 32'(in_ready), 32'd1);
      // asynchronous reset in CALC cycle 10
      @(negedge sys_clock);
      dividend = 20'd100;
      divisor = 4'd3;
      in_valid = 1'b1;
      @(posedge sys_clock);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge sys_clock);
      #2;
      chk("ar busy in_ready", 32'(in_ready), 32'd0);
      chk("ar busy out_valid", 32'(out_valid), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("ar in_ready", 32'(in_ready), 32'd1);
      chk("ar out_valid", 32'(out_valid), 32'd0);
      @(negedge sys_clock) reset_n = 1'b1;
      run_op("after_reset 9/3", 20'd9, 4'd3, 1'b0, 20'd3, 4'd0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
